// File: rtl/cmd_fetch.sv
// Command list fetcher: reads 128-bit commands as four 32-bit DMA words and
// queues them in a first-word-fall-through FIFO for the downstream control block.
module cmd_fetch #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] CMD_BASE   = 32'h0000_0000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [6:0]                           cmd_size,
   output logic                                 rd_req,
   output logic [31:0]                          rd_addr,
   input  logic                                 rd_gnt,
   input  logic                                 rd_valid,
   input  logic [31:0]                          rd_data,
   output logic                                 cmd_valid,
   input  logic                                 cmd_ready,
   output logic [2:0]                           op_type,
   output logic [7:0]                           stride_1,
   output logic [15:0]                          stride_2,
   output logic [15:0]                          ich_size,
   output logic [15:0]                          och_size,
   output logic [31:0]                          start_addr,
   output logic [31:0]                          wb_addr,
   output logic                                 cmd_fifo_empty,
   output logic                                 busy,
   output logic                                 done,
   output logic [2:0]                           fsm_state,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_PUSH  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      word_idx;
   logic [4:0]      cmd_total;
   logic [4:0]      cmd_cnt;
   logic [4:0]      start_cnt;
   logic [31:0]     slot [4];
   logic [127:0]    mem [FIFO_DEPTH];
   logic [127:0]    head;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            fifo_full;
   logic            granted;
   logic            word_in;
   logic            push;
   logic            pop;
   logic            last_cmd;
   logic            unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign start_cnt = cmd_size[6:2];
   assign fifo_full = (count == CW'(FIFO_DEPTH));
   // A new command is only begun when the FIFO has room for it, so PUSH never overflows.
   assign rd_req    = (state == S_REQ) && !((word_idx == 2'd0) && fifo_full);
   assign granted   = rd_req && rd_gnt;
   assign word_in   = (state == S_WAIT) && rd_valid;
   assign push      = (state == S_PUSH);
   // Both handshakes transfer on a cycle where valid/req and ready/gnt are high at the rising edge.
   assign pop       = cmd_valid && cmd_ready;
   assign last_cmd  = ((cmd_cnt + 5'd1) == cmd_total);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (start_cnt == 5'd0) ? S_DRAIN : S_REQ;
         S_REQ:   if (granted) state_nxt = S_WAIT;
         S_WAIT:  if (rd_valid) state_nxt = (word_idx == 2'd3) ? S_PUSH : S_REQ;
         S_PUSH:  state_nxt = last_cmd ? S_DRAIN : S_REQ;
         S_DRAIN: if (count == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx  <= 2'd0;
         cmd_total <= 5'd0;
         cmd_cnt   <= 5'd0;
         rd_addr   <= 32'd0;
         done      <= 1'b0;
      end else begin
         if ((state == S_IDLE) && start) begin
            done      <= 1'b0;
            cmd_total <= start_cnt;
            cmd_cnt   <= 5'd0;
            word_idx  <= 2'd0;
            if (start_cnt != 5'd0) rd_addr <= CMD_BASE;
         end
         if (word_in) begin
            rd_addr <= rd_addr + 32'd4;
            if (word_idx != 2'd3) word_idx <= word_idx + 2'd1;
         end
         if (push) begin
            cmd_cnt  <= cmd_cnt + 5'd1;
            word_idx <= 2'd0;
         end
         if ((state == S_DRAIN) && (count == '0)) done <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (word_in) slot[word_idx] <= rd_data;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {slot[3], slot[2], slot[1], slot[0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Word0 sits in the low 32 bits of each entry (lowest address first).
   assign head           = mem[rd_ptr];
   assign op_type        = head[2:0];
   assign stride_1       = head[15:8];
   assign stride_2       = head[31:16];
   assign ich_size       = head[47:32];
   assign och_size       = head[63:48];
   assign start_addr     = head[95:64];
   assign wb_addr        = head[127:96];
   assign cmd_valid      = (count != '0);
   assign cmd_fifo_empty = !cmd_valid;
   assign busy           = (state != S_IDLE);
   assign fsm_state      = state;
   assign fifo_level     = count;
   assign unused_bits    = ^{cmd_size[1:0], head[7:3]};

endmodule
